// File: rtl/score_pkg.sv
// Shared types and 3x5 digit glyphs for the score keeper.
// Glyph rows are packed MSB-first, top row in bits [14:12].
package score_pkg;

  localparam int unsigned GlyphW = 15;

  typedef logic [3:0]        bcd_t;
  typedef logic [GlyphW-1:0] glyph_t;

  typedef enum logic {PLAYING, GAME_OVER} state_t;

  localparam glyph_t Glyph0 = 15'b111_101_101_101_111;
  localparam glyph_t Glyph1 = 15'b010_110_010_010_111;
  localparam glyph_t Glyph2 = 15'b111_001_111_100_111;
  localparam glyph_t Glyph3 = 15'b111_001_111_001_111;
  localparam glyph_t Glyph4 = 15'b101_101_111_001_001;
  localparam glyph_t Glyph5 = 15'b111_100_111_001_111;
  localparam glyph_t Glyph6 = 15'b111_100_111_101_111;
  localparam glyph_t Glyph7 = 15'b111_001_001_001_001;
  localparam glyph_t Glyph8 = 15'b111_101_111_101_111;
  localparam glyph_t Glyph9 = 15'b111_101_111_001_111;

  // Four-digit BCD encoding of a binary value, used to build the win threshold.
  function automatic logic [15:0] int_to_bcd(input int unsigned value);
    logic [15:0]  r;
    int unsigned  v;
    v = value;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      r[k*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

endpackage

// File: rtl/score_if.sv
// Goal/new-game inputs and score/glyph outputs between game logic and score keeper.
interface score_if
  import score_pkg::*;
#(
  parameter int unsigned N_PLAYERS = 2,
  parameter int unsigned DIGITS    = 2,
  parameter int unsigned GLYPH_W   = 15,
  parameter int unsigned WIN_W     = 1
);

  logic [N_PLAYERS-1:0]                            goal_i;
  logic                                            new_game_i;
  bcd_t [N_PLAYERS-1:0][DIGITS-1:0]                score_bcd_o;
  logic [N_PLAYERS-1:0][DIGITS-1:0][GLYPH_W-1:0]   glyph_o;
  logic [N_PLAYERS-1:0][DIGITS-1:0]                digit_en_o;
  logic                                            game_over_o;
  logic [WIN_W-1:0]                                winner_o;
  logic                                            blink_o;

  modport master (
    output goal_i, new_game_i,
    input  score_bcd_o, glyph_o, digit_en_o, game_over_o, winner_o, blink_o
  );

  modport slave (
    input  goal_i, new_game_i,
    output score_bcd_o, glyph_o, digit_en_o, game_over_o, winner_o, blink_o
  );

endinterface

// File: rtl/score_glyph_rom.sv
// Combinational BCD digit to 3x5 glyph bitmap; non-decimal nibbles give a blank glyph.
module score_glyph_rom
  import score_pkg::*;
(
  input  bcd_t   bcd_i,
  output glyph_t glyph_o
);

  always_comb begin
    glyph_o = '0;
    case (bcd_i)
      4'd0:    glyph_o = Glyph0;
      4'd1:    glyph_o = Glyph1;
      4'd2:    glyph_o = Glyph2;
      4'd3:    glyph_o = Glyph3;
      4'd4:    glyph_o = Glyph4;
      4'd5:    glyph_o = Glyph5;
      4'd6:    glyph_o = Glyph6;
      4'd7:    glyph_o = Glyph7;
      4'd8:    glyph_o = Glyph8;
      4'd9:    glyph_o = Glyph9;
      default: glyph_o = '0;
    endcase
  end

endmodule

// File: rtl/score_keeper.sv
// Per-player saturating BCD scores, win detection with blinking winner indication,
// and registered per-digit glyphs with leading-zero blanking.
module score_keeper
  import score_pkg::*;
#(
  parameter int unsigned N_PLAYERS    = 2,
  parameter int unsigned DIGITS       = 2,
  parameter int unsigned WIN_SCORE    = 11,
  parameter int unsigned GLYPH_W      = 15,
  parameter int unsigned BLINK_CYCLES = 25_000_000,
  parameter int unsigned WIN_W        = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1
) (
  input logic    clk_i,
  input logic    rst_i,
  score_if.slave bus
);

  localparam int unsigned CntW   = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam int unsigned ScoreW = DIGITS * 4;
  localparam logic [15:0] WinBcd16 = int_to_bcd(WIN_SCORE);
  localparam logic [ScoreW-1:0] WinBcd = WinBcd16[ScoreW-1:0];

  if (N_PLAYERS < 2 || N_PLAYERS > 8) begin : g_bad_players
    $error("score_keeper: N_PLAYERS out of range 2..8");
  end
  if (DIGITS < 1 || DIGITS > 4) begin : g_bad_digits
    $error("score_keeper: DIGITS out of range 1..4");
  end
  if (WIN_SCORE < 1 || WIN_SCORE > (10 ** DIGITS) - 1) begin : g_bad_win
    $error("score_keeper: WIN_SCORE not representable in DIGITS");
  end
  if (GLYPH_W != GlyphW) begin : g_bad_glyph
    $error("score_keeper: GLYPH_W must match the glyph font width");
  end

  state_t                              state_q;
  bcd_t   [N_PLAYERS-1:0][DIGITS-1:0]  score_q, score_nxt;
  logic   [N_PLAYERS-1:0]              reached;
  logic   [WIN_W-1:0]                  winner_q, win_idx;
  logic                                blink_q;
  logic   [CntW-1:0]                   cnt_q;
  glyph_t [N_PLAYERS-1:0][DIGITS-1:0]  glyph_d, glyph_q;
  logic   [N_PLAYERS-1:0][DIGITS-1:0]  en_d, en_q;

  for (genvar p = 0; p < N_PLAYERS; p++) begin : g_player
    bcd_t [DIGITS-1:0] nxt;

    // Ripple BCD increment; an all-9s score stays put instead of wrapping.
    always_comb begin
      logic sat;
      logic carry;
      sat = 1'b1;
      for (int k = 0; k < DIGITS; k++) begin
        if (score_q[p][k] != 4'd9) sat = 1'b0;
      end
      carry = bus.goal_i[p] & ~sat;
      nxt   = score_q[p];
      for (int k = 0; k < DIGITS; k++) begin
        if (carry) begin
          if (score_q[p][k] == 4'd9) begin
            nxt[k] = 4'd0;
          end else begin
            nxt[k] = score_q[p][k] + 4'd1;
            carry  = 1'b0;
          end
        end
      end
    end

    assign score_nxt[p] = nxt;
    assign reached[p]   = (nxt == WinBcd);

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
      score_glyph_rom u_rom (
        .bcd_i   (score_q[p][k]),
        .glyph_o (glyph_d[p][k])
      );
    end
  end

  // Lowest index wins a tie.
  always_comb begin
    win_idx = '0;
    for (int p = N_PLAYERS - 1; p >= 0; p--) begin
      if (reached[p]) win_idx = WIN_W'(p);
    end
  end

  always_comb begin
    en_d = '0;
    for (int p = 0; p < N_PLAYERS; p++) begin
      logic any_nz;
      any_nz = 1'b0;
      for (int k = DIGITS - 1; k >= 0; k--) begin
        any_nz     = any_nz | (score_q[p][k] != 4'd0);
        en_d[p][k] = any_nz | (k == 0);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= PLAYING;
      score_q  <= '0;
      winner_q <= '0;
      blink_q  <= 1'b1;
      cnt_q    <= '0;
    end else if (bus.new_game_i) begin
      state_q  <= PLAYING;
      score_q  <= '0;
      blink_q  <= 1'b1;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        PLAYING: begin
          score_q <= score_nxt;
          if (|reached) begin
            state_q  <= GAME_OVER;
            winner_q <= win_idx;
            blink_q  <= 1'b1;
            cnt_q    <= '0;
          end
        end
        GAME_OVER: begin
          if (cnt_q == CntW'(BLINK_CYCLES - 1)) begin
            cnt_q   <= '0;
            blink_q <= ~blink_q;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: state_q <= PLAYING;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int p = 0; p < N_PLAYERS; p++) begin
        for (int k = 0; k < DIGITS; k++) begin
          glyph_q[p][k] <= Glyph0;
          en_q[p][k]    <= (k == 0);
        end
      end
    end else begin
      glyph_q <= glyph_d;
      en_q    <= en_d;
    end
  end

  assign bus.score_bcd_o = score_q;
  assign bus.glyph_o     = glyph_q;
  assign bus.digit_en_o  = en_q;
  assign bus.game_over_o = (state_q == GAME_OVER);
  assign bus.winner_o    = winner_q;
  assign bus.blink_o     = blink_q;

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper: two configurations, decimal reference model,
// expectations queued at drive time and popped after the clock edge.
module tb_score_keeper;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;

  score_if #(.N_PLAYERS(2), .DIGITS(2), .GLYPH_W(15), .WIN_W(1)) bus_a ();
  score_if #(.N_PLAYERS(3), .DIGITS(1), .GLYPH_W(15), .WIN_W(2)) bus_b ();

  score_keeper #(
    .N_PLAYERS(2), .DIGITS(2), .WIN_SCORE(11), .GLYPH_W(15), .BLINK_CYCLES(4), .WIN_W(1)
  ) dut_a (
    .clk_i (clk),
    .rst_i (rst_a),
    .bus   (bus_a)
  );

  score_keeper #(
    .N_PLAYERS(3), .DIGITS(1), .WIN_SCORE(9), .GLYPH_W(15), .BLINK_CYCLES(4), .WIN_W(2)
  ) dut_b (
    .clk_i (clk),
    .rst_i (rst_b),
    .bus   (bus_b)
  );

  typedef struct {
    logic [63:0] score;
    logic [63:0] glyph;
    logic [63:0] en;
    logic        go;
    logic [1:0]  win;
    logic        blink;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model state, decimal scores
  int cfg_n, cfg_d, cfg_win, cfg_max;
  int m_sc[3];
  bit m_go;
  int m_win;
  bit m_blink;
  int m_cnt;

  function automatic logic [14:0] glyph_of(input int d);
    case (d)
      0: return 15'b111_101_101_101_111;
      1: return 15'b010_110_010_010_111;
      2: return 15'b111_001_111_100_111;
      3: return 15'b111_001_111_001_111;
      4: return 15'b101_101_111_001_001;
      5: return 15'b111_100_111_001_111;
      6: return 15'b111_100_111_101_111;
      7: return 15'b111_001_001_001_001;
      8: return 15'b111_101_111_101_111;
      9: return 15'b111_101_111_001_111;
      default: return 15'b0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic [2:0] goal, input bit ng, input bit rst);
    if (rst) begin
      for (int p = 0; p < 3; p++) m_sc[p] = 0;
      m_go = 0; m_win = 0; m_blink = 1; m_cnt = 0;
    end else if (ng) begin
      for (int p = 0; p < 3; p++) m_sc[p] = 0;
      m_go = 0; m_blink = 1; m_cnt = 0;
    end else if (!m_go) begin
      for (int p = 0; p < cfg_n; p++) begin
        if (goal[p] && m_sc[p] < cfg_max) m_sc[p]++;
      end
      for (int p = cfg_n - 1; p >= 0; p--) begin
        if (m_sc[p] == cfg_win) begin
          m_go = 1; m_win = p; m_blink = 1; m_cnt = 0;
        end
      end
    end else begin
      if (m_cnt == 3) begin
        m_cnt = 0;
        m_blink = !m_blink;
      end else begin
        m_cnt++;
      end
    end
  endtask

  task automatic step(input int dut, input logic [2:0] goal, input bit ng, input bit rst);
    exp_t        e;
    int          src[3];
    int          base;
    string       nm;
    logic [63:0] o_score, o_glyph, o_en;
    logic        o_go, o_blink;
    logic [1:0]  o_win;
    @(negedge clk);
    if (dut == 0) begin
      bus_a.goal_i = goal[1:0]; bus_a.new_game_i = ng; rst_a = rst;
    end else begin
      bus_b.goal_i = goal; bus_b.new_game_i = ng; rst_b = rst;
    end
    // Glyphs at this edge reflect the score held before it (reset forces digit 0 glyphs).
    for (int p = 0; p < 3; p++) src[p] = rst ? 0 : m_sc[p];
    e.glyph = '0;
    e.en    = '0;
    for (int p = 0; p < cfg_n; p++) begin
      for (int k = 0; k < cfg_d; k++) begin
        base = p * cfg_d + k;
        e.glyph[base*15 +: 15] = glyph_of((src[p] / (10 ** k)) % 10);
        e.en[base] = (k == 0) || (src[p] >= 10 ** k);
      end
    end
    model_step(goal, ng, rst);
    e.score = '0;
    for (int p = 0; p < cfg_n; p++) begin
      for (int k = 0; k < cfg_d; k++) begin
        base = p * cfg_d + k;
        e.score[base*4 +: 4] = 4'((m_sc[p] / (10 ** k)) % 10);
      end
    end
    e.go    = m_go;
    e.win   = 2'(m_win);
    e.blink = m_blink;
    sb.push_back(e);

    @(posedge clk);
    #1;
    if (dut == 0) begin
      nm = "a";
      o_score = 64'(bus_a.score_bcd_o); o_glyph = 64'(bus_a.glyph_o);
      o_en = 64'(bus_a.digit_en_o); o_go = bus_a.game_over_o;
      o_win = 2'(bus_a.winner_o); o_blink = bus_a.blink_o;
    end else begin
      nm = "b";
      o_score = 64'(bus_b.score_bcd_o); o_glyph = 64'(bus_b.glyph_o);
      o_en = 64'(bus_b.digit_en_o); o_go = bus_b.game_over_o;
      o_win = bus_b.winner_o; o_blink = bus_b.blink_o;
    end
    if (sb.size() == 0) begin
      check({nm, ".scoreboard_nonempty"}, 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      check({nm, ".score_bcd"}, o_score, e.score);
      check({nm, ".glyph"},     o_glyph, e.glyph);
      check({nm, ".digit_en"},  o_en,    e.en);
      check({nm, ".game_over"}, 64'(o_go),    64'(e.go));
      check({nm, ".winner"},    64'(o_win),   64'(e.win));
      check({nm, ".blink"},     64'(o_blink), 64'(e.blink));
    end
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    bus_a.goal_i = '0; bus_a.new_game_i = 1'b0;
    bus_b.goal_i = '0; bus_b.new_game_i = 1'b0;

    // Configuration A: 2 players, 2 digits, win at 11
    cfg_n = 2; cfg_d = 2; cfg_win = 11; cfg_max = 99;
    for (int p = 0; p < 3; p++) m_sc[p] = 0;
    m_go = 0; m_win = 0; m_blink = 1; m_cnt = 0;

    step(0, 3'b000, 0, 1);
    step(0, 3'b000, 0, 1);
    repeat (10) step(0, 3'b001, 0, 0);   // carry into tens digit
    step(0, 3'b000, 0, 0);
    repeat (10) step(0, 3'b010, 0, 0);
    step(0, 3'b011, 0, 0);               // simultaneous goals, tie at 11
    step(0, 3'b010, 0, 0);               // frozen in game over
    repeat (9) step(0, 3'b000, 0, 0);    // blink pattern
    step(0, 3'b001, 1, 0);               // new game drops same-cycle goal
    repeat (5) step(0, 3'b001, 0, 0);
    step(0, 3'b000, 1, 1);               // reset beats new game
    step(0, 3'b000, 0, 0);
    step(0, 3'b001, 0, 0);

    // Configuration B: 3 players, 1 digit, win at 9
    cfg_n = 3; cfg_d = 1; cfg_win = 9; cfg_max = 9;
    step(1, 3'b000, 0, 1);
    step(1, 3'b000, 0, 1);
    repeat (9) step(1, 3'b100, 0, 0);
    step(1, 3'b101, 0, 0);
    step(1, 3'b111, 0, 0);
    repeat (3) step(1, 3'b000, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
